// File: rtl/hamming_enc_engine.sv
// SECDED Hamming encoder engine: walks data memory, turning
// 11-bit messages into 16-bit even-parity codewords.
module hamming_enc_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

    logic [2:0]    r_state;
    logic [6:0]    r_idx;
    logic [11:1]   r_d;

    logic          w_p8;
    logic          w_p4;
    logic          w_p2;
    logic          w_p1;
    logic          w_p0;
    logic [15:0]   w_cw;
    logic [AW-1:0] w_off;
    logic [AW-1:0] w_src_lo;
    logic [AW-1:0] w_dst_lo;
    logic          w_unused_rd;

    // High message byte only carries d[11:9]; the rest is don't-care.
    assign w_unused_rd = ^mem_rd_data[7:3];

    // Parity over the latched message, laid out in Hamming positions.
    assign w_p8 = ^r_d[11:5];
    assign w_p4 = (^r_d[11:8]) ^ (^r_d[4:2]);
    assign w_p2 = r_d[11] ^ r_d[10] ^ r_d[7] ^ r_d[6]
                ^ r_d[4] ^ r_d[3] ^ r_d[1];
    assign w_p1 = r_d[11] ^ r_d[9] ^ r_d[7] ^ r_d[5]
                ^ r_d[4] ^ r_d[2] ^ r_d[1];
    assign w_p0 = (^r_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
    assign w_cw = {r_d[11:5], w_p8, r_d[4:2], w_p4,
                   r_d[1], w_p2, w_p1, w_p0};

    // Byte offsets wrap modulo 2^AW by construction.
    assign w_off    = AW'({r_idx, 1'b0});
    assign w_src_lo = AW'(SRC_BASE) + w_off;
    assign w_dst_lo = AW'(DST_BASE) + w_off;

    // Sequencer: read lo, read hi, write lo, write hi per message.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_d     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_state <= S_RD_LO;
                        r_idx   <= '0;
                    end
                end
                S_RD_LO: begin
                    r_d[8:1] <= mem_rd_data;
                    r_state  <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_d[11:9] <= mem_rd_data[2:0];
                    r_state   <= S_WR_LO;
                end
                S_WR_LO: begin
                    r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 7'd1;
                        r_state <= S_RD_LO;
                    end
                end
                S_DONE: begin
                    if (init) begin
                        r_state <= S_RD_LO;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port and status decode straight from the state.
    always_comb begin
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (r_state)
            S_RD_LO: begin
                mem_addr = w_src_lo;
            end
            S_RD_HI: begin
                mem_addr = w_src_lo + AW'(1);
            end
            S_WR_LO: begin
                mem_addr    = w_dst_lo;
                mem_wr_en   = 1'b1;
                mem_wr_data = w_cw[7:0];
            end
            S_WR_HI: begin
                mem_addr    = w_dst_lo + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = w_cw[15:8];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Bench for hamming_enc_engine: two instances (15 and 1 message)
// each with its own byte memory, checked against a Hamming model.
module tb_hamming_enc_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_a;
    logic       init_b;
    logic       done_a;
    logic       done_b;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       we_a;
    logic       we_b;
    logic [7:0] wd_a;
    logic [7:0] wd_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] src [30];
    int         n_wr_a = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    hamming_enc_engine #(
        .NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30), .AW(8)
    ) u_dut (
        .clk(clk), .reset(reset), .init(init_a), .done(done_a),
        .mem_addr(addr_a), .mem_rd_data(rd_a),
        .mem_wr_en(we_a), .mem_wr_data(wd_a)
    );

    hamming_enc_engine #(
        .NUM_MSG(1), .SRC_BASE(0), .DST_BASE(30), .AW(8)
    ) u_one (
        .clk(clk), .reset(reset), .init(init_b), .done(done_b),
        .mem_addr(addr_b), .mem_rd_data(rd_b),
        .mem_wr_en(we_b), .mem_wr_data(wd_b)
    );

    assign rd_a = mem_a[addr_a];
    assign rd_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= wd_a;
            n_wr_a <= n_wr_a + 1;
        end
        if (we_b) begin
            mem_b[addr_b] <= wd_b;
        end
    end

    // Reference: data in non-power-of-two positions 3..15, each parity
    // bit at position k covers positions with bit k set, p0 evens all.
    function automatic logic [15:0] ref_cw(input logic [10:0] m);
        logic [15:0] c;
        int b;
        c = '0;
        b = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = m[b];
                b++;
            end
        end
        for (int k = 1; k < 16; k = k * 2) begin
            for (int p = 1; p < 16; p++) begin
                if (((p & k) != 0) && (p != k)) c[k] = c[k] ^ c[p];
            end
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] msg(input int i);
        return {src[2*i+1][2:0], src[2*i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_init(input bit sel, input logic v);
        if (sel) init_b = v;
        else init_a = v;
    endtask

    // Start a run and count edges from the one that samples init
    // until done is seen; optional one-cycle init pulse mid-run.
    task automatic run(input bit sel, input int pulse_at,
                       output int cyc);
        set_init(sel, 1'b1);
        @(negedge clk);
        set_init(sel, 1'b0);
        cyc = 1;
        while (!(sel ? done_b : done_a) && cyc < 600) begin
            set_init(sel, cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        set_init(sel, 1'b0);
    endtask

    task automatic load_random();
        for (int i = 0; i < 30; i++) begin
            mem_a[i] = 8'($urandom);
            src[i]   = mem_a[i];
        end
        for (int i = 30; i < 60; i++) mem_a[i] = 8'hA5;
    endtask

    task automatic set_msg(input int i, input logic [7:0] lo,
                           input logic [7:0] hi);
        mem_a[2*i]   = lo;
        mem_a[2*i+1] = hi;
        src[2*i]     = lo;
        src[2*i+1]   = hi;
    endtask

    task automatic check_cws(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cw%0d", tag, i),
                32'({mem_a[31+2*i], mem_a[30+2*i]}),
                32'(ref_cw(msg(i))));
        end
    endtask

    initial begin
        int cyc;
        int w0;
        int dq[$];
        logic [15:0] cw7;

        reset  = 1'b1;
        init_a = 1'b0;
        init_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_wen", 32'(we_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_wdata", 32'(wd_a), 0);
        chk("rst_done_b", 32'(done_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // single all-ones message on the one-message instance
        mem_b[0] = 8'hFF;
        mem_b[1] = 8'h07;
        run(1'b1, -1, cyc);
        chk("t1_latency", 32'(cyc), 5);
        chk("t1_lo", 32'(mem_b[30]), 32'h FF);
        chk("t1_hi", 32'(mem_b[31]), 32'h FF);

        // directed corner messages followed by random ones
        load_random();
        set_msg(0, 8'hFF, 8'h07);
        set_msg(1, 8'h01, 8'h00);
        set_msg(2, 8'h00, 8'h04);
        set_msg(3, 8'h00, 8'h00);
        set_msg(4, 8'h00, 8'hF8);
        w0 = n_wr_a;
        run(1'b0, -1, cyc);
        chk("t4_latency", 32'(cyc), 61);
        chk("t2_7ff", 32'({mem_a[31], mem_a[30]}), 32'h FFFF);
        chk("t2_001", 32'({mem_a[33], mem_a[32]}), 32'h 000F);
        chk("t2_400", 32'({mem_a[35], mem_a[34]}), 32'h 8117);
        chk("t2_000", 32'({mem_a[37], mem_a[36]}), 32'h 0000);
        chk("t3_f8", 32'({mem_a[39], mem_a[38]}), 32'h 0000);
        check_cws("t4", 15);
        chk("t4_writes", 32'(n_wr_a - w0), 30);
        chk("t4_past_dst", 32'(mem_a[60]), 32'h00);
        repeat (3) @(negedge clk);
        chk("t4_done_hold", 32'(done_a), 1);
        chk("t4_idle_wen", 32'(we_a), 0);

        // init pulse mid-run must not restart anything
        load_random();
        w0 = n_wr_a;
        run(1'b0, 10, cyc);
        chk("t6_pulse_latency", 32'(cyc), 61);
        chk("t6_pulse_writes", 32'(n_wr_a - w0), 30);
        check_cws("t6p", 15);

        // reset while writing the low byte of message 7
        load_random();
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        cyc = 1;
        while (cyc < 31) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_in_wrlo", 32'(we_a), 1);
        chk("t5_addr7", 32'(addr_a), 44);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_done", 32'(done_a), 0);
        chk("t5_wen", 32'(we_a), 0);
        chk("t5_addr", 32'(addr_a), 0);
        chk("t5_wdata", 32'(wd_a), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_done", 32'(done_a), 0);
        check_cws("t5", 7);
        cw7 = ref_cw(msg(7));
        chk("t5_cw7_lo", 32'(mem_a[44]), 32'(cw7[7:0]));
        chk("t5_cw7_hi", 32'(mem_a[45]), 32'h A5);
        w0 = n_wr_a;
        run(1'b0, -1, cyc);
        chk("t5_rerun_latency", 32'(cyc), 61);
        chk("t5_rerun_writes", 32'(n_wr_a - w0), 30);
        check_cws("t5r", 15);

        // init held high: back-to-back runs, one-cycle done each
        load_random();
        w0 = n_wr_a;
        init_a = 1'b1;
        for (int n = 1; n <= 125; n++) begin
            @(negedge clk);
            if (done_a) dq.push_back(n);
        end
        init_a = 1'b0;
        chk("t6_hold_count", 32'(dq.size()), 2);
        if (dq.size() == 2) begin
            chk("t6_hold_first", 32'(dq[0]), 61);
            chk("t6_hold_second", 32'(dq[1]), 122);
        end
        check_cws("t6h", 15);
        cyc = 0;
        while (!done_a && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_hold_finish", 32'(done_a), 1);
        chk("t6_hold_writes", 32'(n_wr_a - w0), 90);
        check_cws("t6f", 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
